// File: rtl/axis_hdr_insert_q_if.sv
// Bus bundle for axis_hdr_insert_q: payload input, header input and output stream.
// slave is the inserter's view, master is the surrounding environment's view.
interface axis_hdr_insert_q_if #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
);
  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
    output ready_insert,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    output valid_insert, data_insert, keep_insert, byte_insert_cnt,
    input  ready_insert,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out
  );
endinterface

// File: rtl/axis_hdr_insert_q.sv
// AXI-Stream header inserter: queued headers are prepended to packets and the payload is re-packed
// byte-contiguously. Define AXIS_HDR_INS_CHECK_EN to add the hdr_err keep-consistency checker.
module axis_hdr_insert_q #(
  parameter int DATA_WD        = 32,
  parameter int DATA_BYTE_WD   = DATA_WD / 8,
  parameter int BYTE_CNT_WD    = $clog2(DATA_BYTE_WD + 1),
  parameter int HDR_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_hdr_insert_q_if.slave   bus
`ifdef AXIS_HDR_INS_CHECK_EN
  ,
  output logic                 hdr_err
`endif
);
  localparam int PTR_WD = $clog2(HDR_FIFO_DEPTH);
  localparam logic [BYTE_CNT_WD-1:0] W_CNT = BYTE_CNT_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {S_FIRST = 2'd0, S_BODY = 2'd1, S_TAIL = 2'd2} state_t;

  function automatic logic [DATA_BYTE_WD-1:0] msb_mask(input logic [BYTE_CNT_WD:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = (i < int'(cnt));
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{keep[i]}};
    return m;
  endfunction

  function automatic logic [BYTE_CNT_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] keep);
    logic [BYTE_CNT_WD-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + BYTE_CNT_WD'(keep[i]);
    return c;
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_WD-1:0]      fifo_data_q [HDR_FIFO_DEPTH];
  logic [DATA_WD-1:0]      fifo_data_d [HDR_FIFO_DEPTH];
  logic [BYTE_CNT_WD-1:0]  fifo_cnt_q  [HDR_FIFO_DEPTH];
  logic [BYTE_CNT_WD-1:0]  fifo_cnt_d  [HDR_FIFO_DEPTH];
  logic [PTR_WD:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                    fifo_full, fifo_empty, push, pop;
  logic [BYTE_CNT_WD-1:0]  ins_cnt, head_cnt;
  logic [DATA_WD-1:0]      head_data;

  logic [DATA_WD-1:0]      carry_q, carry_d;
  logic [BYTE_CNT_WD-1:0]  cnt_q, cnt_d, tail_cnt_q, tail_cnt_d;
  logic                    valid_out_q, valid_out_d, last_out_q, last_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;

  logic                    slot_free, ready_in, accept, fits;
  logic [BYTE_CNT_WD-1:0]  n_eff, k_in;
  logic [DATA_WD-1:0]      c_eff, beat_out, carry_next;
  logic [BYTE_CNT_WD:0]    nk;

  // Header FIFO: a full FIFO refuses pushes even when a pop happens in the same cycle.
  assign fifo_empty       = (wr_ptr_q == rd_ptr_q);
  assign fifo_full        = (wr_ptr_q[PTR_WD] != rd_ptr_q[PTR_WD]) &&
                            (wr_ptr_q[PTR_WD-1:0] == rd_ptr_q[PTR_WD-1:0]);
  assign ins_cnt          = (bus.byte_insert_cnt > W_CNT) ? W_CNT : bus.byte_insert_cnt;
  assign push             = bus.valid_insert && !fifo_full;
  assign pop              = accept && (state_q == S_FIRST);
  assign head_data        = fifo_data_q[rd_ptr_q[PTR_WD-1:0]];
  assign head_cnt         = fifo_cnt_q[rd_ptr_q[PTR_WD-1:0]];
  assign bus.ready_insert = !fifo_full;

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push) begin
      fifo_data_d[wr_ptr_q[PTR_WD-1:0]] = bus.data_insert;
      fifo_cnt_d[wr_ptr_q[PTR_WD-1:0]]  = ins_cnt;
      wr_ptr_d = wr_ptr_q + (PTR_WD+1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PTR_WD+1)'(1);
  end

  // On a first beat the carry comes straight from the FIFO head, moved to the MSB side.
  always_comb begin
    n_eff      = (state_q == S_FIRST) ? head_cnt : cnt_q;
    c_eff      = (state_q == S_FIRST) ? (head_data << {W_CNT - head_cnt, 3'b000}) : carry_q;
    beat_out   = c_eff | (bus.data_in >> {n_eff, 3'b000});
    carry_next = bus.data_in << {W_CNT - n_eff, 3'b000};
    k_in       = popcount(bus.keep_in);
    nk         = {1'b0, n_eff} + {1'b0, k_in};
    fits       = (nk <= {1'b0, W_CNT});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FIRST;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FIRST, S_BODY: begin
        if (accept) begin
          if (!bus.last_in) state_d = S_BODY;
          else              state_d = fits ? S_FIRST : S_TAIL;
        end
      end
      S_TAIL:  if (slot_free) state_d = S_FIRST;
      default: state_d = S_FIRST;
    endcase
  end

  always_comb begin
    slot_free = !valid_out_q || bus.ready_out;
    unique case (state_q)
      S_FIRST: ready_in = !fifo_empty && slot_free;
      S_BODY:  ready_in = slot_free;
      default: ready_in = 1'b0;
    endcase
    accept = bus.valid_in && ready_in;

    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    tail_cnt_d  = tail_cnt_q;
    if (slot_free) begin
      valid_out_d = 1'b0;
      data_out_d  = '0;
      keep_out_d  = '0;
      last_out_d  = 1'b0;
    end
    if (accept) begin
      valid_out_d = 1'b1;
      carry_d     = carry_next;
      cnt_d       = n_eff;
      if (bus.last_in && fits) begin
        keep_out_d = msb_mask(nk);
        data_out_d = beat_out & byte_mask(msb_mask(nk));
        last_out_d = 1'b1;
      end else begin
        keep_out_d = '1;
        data_out_d = beat_out;
        last_out_d = 1'b0;
        if (bus.last_in) tail_cnt_d = BYTE_CNT_WD'(nk - {1'b0, W_CNT});
      end
    end else if (state_q == S_TAIL && slot_free) begin
      valid_out_d = 1'b1;
      keep_out_d  = msb_mask({1'b0, tail_cnt_q});
      data_out_d  = carry_q & byte_mask(msb_mask({1'b0, tail_cnt_q}));
      last_out_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HDR_FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_cnt_q[i]  <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      tail_cnt_q  <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      tail_cnt_q  <= tail_cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
    end
  end

  assign bus.ready_in  = ready_in;
  assign bus.valid_out = valid_out_q;
  assign bus.data_out  = data_out_q;
  assign bus.keep_out  = keep_out_q;
  assign bus.last_out  = last_out_q;

`ifdef AXIS_HDR_INS_CHECK_EN
  function automatic logic [DATA_BYTE_WD-1:0] lsb_mask(input logic [BYTE_CNT_WD-1:0] cnt);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i] = (i < int'(cnt));
    return m;
  endfunction

  logic hdr_err_q, hdr_err_d;

  always_comb begin
    hdr_err_d = (push && (bus.keep_insert != lsb_mask(ins_cnt))) ||
                (accept && !bus.last_in && (bus.keep_in != '1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hdr_err_q <= 1'b0;
    else        hdr_err_q <= hdr_err_d;
  end

  assign hdr_err = hdr_err_q;
`else
  logic unused_keep_insert;
  assign unused_keep_insert = ^bus.keep_insert;
`endif
endmodule

// File: tb/tb_axis_hdr_insert_q.sv
// Directed bench for axis_hdr_insert_q (DATA_WD=32): vector table for the basic packets,
// plus hand-written sequences for queued headers with backpressure and mid-packet reset.
module tb_axis_hdr_insert_q;
  logic clk;
  logic rst_n;

  axis_hdr_insert_q_if #(.DATA_WD(32)) bus ();

`ifdef AXIS_HDR_INS_CHECK_EN
  logic hdr_err;
`endif

  axis_hdr_insert_q #(.DATA_WD(32), .HDR_FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef AXIS_HDR_INS_CHECK_EN
    ,
    .hdr_err (hdr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vin;
    logic [31:0] din;
    logic [3:0]  kin;
    logic        lin;
    logic        exp_rdy;
    logic        exp_vout;
    logic [31:0] exp_dout;
    logic [3:0]  exp_kout;
    logic        exp_lout;
  } vec_t;

  vec_t        vecs [12];
  int          n_vec;
  int          n_miss;
  logic [37:0] exp_q [$];
  logic [31:0] h_data [4];
  int          h_n [4];
  logic [31:0] pk_data [3][16];
  logic [3:0]  pk_keep [3][16];
  bit          stream_done;

  function automatic logic [37:0] out_vec();
    return {bus.valid_out, bus.last_out, bus.keep_out, bus.data_out};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_hdr(input logic [31:0] d, input int n);
    bus.valid_insert    = 1'b1;
    bus.data_insert     = d;
    bus.byte_insert_cnt = 3'(n);
    bus.keep_insert     = 4'((1 << n) - 1);
    @(posedge clk); #1;
    bus.valid_insert    = 1'b0;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.valid_in = vecs[i].vin;
      bus.data_in  = vecs[i].din;
      bus.keep_in  = vecs[i].kin;
      bus.last_in  = vecs[i].lin;
      #1;
      chk($sformatf("vec%0d_ready_in", i), 64'(bus.ready_in), 64'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i), 64'(out_vec()),
          64'({vecs[i].exp_vout, vecs[i].exp_lout, vecs[i].exp_kout, vecs[i].exp_dout}));
      $display("vec %0d: in v=%b %h/%h l=%b -> out v=%b %h/%h l=%b", i, vecs[i].vin, vecs[i].din,
               vecs[i].kin, vecs[i].lin, bus.valid_out, bus.data_out, bus.keep_out, bus.last_out);
    end
  endtask

  // Reference model: header bytes then payload bytes as one stream, chunked into W-byte beats.
  task automatic build_expected(input int p);
    logic [7:0]  bq [$];
    logic [31:0] w;
    logic [3:0]  kk;
    int          take;
    for (int i = h_n[p] - 1; i >= 0; i--) bq.push_back(h_data[p][8*i +: 8]);
    for (int b = 0; b < 16; b++)
      for (int j = 0; j < 4; j++)
        if (pk_keep[p][b][3-j]) bq.push_back(pk_data[p][b][31-8*j -: 8]);
    while (bq.size() > 0) begin
      w = '0;
      kk = '0;
      take = (bq.size() < 4) ? bq.size() : 4;
      for (int j = 0; j < take; j++) begin
        w[31-8*j -: 8] = bq.pop_front();
        kk[3-j] = 1'b1;
      end
      exp_q.push_back({1'b1, (bq.size() == 0), kk, w});
    end
  endtask

  task automatic drive_packets();
    bit acc;
    int guard;
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 16; b++) begin
        bus.valid_in = 1'b1;
        bus.data_in  = pk_data[p][b];
        bus.keep_in  = pk_keep[p][b];
        bus.last_in  = (b == 15);
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 200) begin
          @(negedge clk);
          acc = bus.ready_in;
          @(posedge clk); #1;
          guard++;
        end
        if (!acc) begin
          chk("drv_accept", 64'(acc), 64'(1));
          bus.valid_in = 1'b0;
          return;
        end
        if (p == 0 && b == 0) chk("ready_insert_after_pop", 64'(bus.ready_insert), 64'(1));
      end
    end
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
  endtask

  task automatic monitor(input int total);
    int          got, cyc, bubbles;
    bit          started, prev_stall;
    logic [37:0] held, e;
    got = 0; cyc = 0; bubbles = 0; started = 0; prev_stall = 0; held = '0;
    while (got < total && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) chk($sformatf("stall_hold%0d", got), 64'(out_vec()), 64'(held));
      if (bus.valid_out) started = 1'b1;
      else if (started) bubbles++;
      if (bus.valid_out && bus.ready_out) begin
        e = exp_q.pop_front();
        chk($sformatf("stream_beat%0d", got), 64'(out_vec()), 64'(e));
        $display("beat %0d: %h/%h l=%b", got, bus.data_out, bus.keep_out, bus.last_out);
        got++;
      end
      prev_stall = bus.valid_out && !bus.ready_out;
      held = out_vec();
    end
    chk("stream_beat_count", 64'(got), 64'(total));
    chk("stream_bubbles", 64'(bubbles), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b0;
    int          total;
    logic [3:0]  last_keeps [4];
    last_keeps = '{4'h8, 4'hC, 4'hE, 4'hF};

    vecs[0]  = '{1'b1, 32'h11223344, 4'hF, 1'b0, 1'b1, 1'b1, 32'hAABB1122, 4'hF, 1'b0};
    vecs[1]  = '{1'b1, 32'h55667788, 4'hE, 1'b1, 1'b1, 1'b1, 32'h33445566, 4'hF, 1'b0};
    vecs[2]  = '{1'b1, 32'h01020304, 4'hC, 1'b1, 1'b0, 1'b1, 32'h77000000, 4'h8, 1'b1};
    vecs[3]  = '{1'b1, 32'h01020304, 4'hC, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0};
    vecs[4]  = '{1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b1, 32'h01020000, 4'hC, 1'b1};
    vecs[5]  = '{1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0};
    vecs[6]  = '{1'b1, 32'h12345678, 4'h8, 1'b1, 1'b1, 1'b1, 32'h12000000, 4'h8, 1'b1};
    vecs[7]  = '{1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};
    vecs[8]  = '{1'b1, 32'hA1B2C3D4, 4'hF, 1'b0, 1'b1, 1'b1, 32'h112233A1, 4'hF, 1'b0};
    vecs[9]  = '{1'b1, 32'hE5F60000, 4'hC, 1'b1, 1'b1, 1'b1, 32'hB2C3D4E5, 4'hF, 1'b0};
    vecs[10] = '{1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b1, 32'hF6000000, 4'h8, 1'b1};
    vecs[11] = '{1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 1'b0, 32'h00000000, 4'h0, 1'b0};

    n_vec = 0;
    n_miss = 0;
    stream_done = 1'b0;
    rst_n = 1'b0;
    bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
    bus.valid_insert = 1'b0; bus.data_insert = '0; bus.keep_insert = '0; bus.byte_insert_cnt = '0;
    bus.ready_out = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 64'(out_vec()), 64'(0));
    chk("reset_ready_in", 64'(bus.ready_in), 64'(0));
    chk("reset_ready_insert", 64'(bus.ready_insert), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // n=2, n=4 and n=0 packets through the vector table
    push_hdr(32'h0000AABB, 2);
    push_hdr(32'hDEADBEEF, 4);
    push_hdr(32'h00000000, 0);
    apply_vecs(0, 7);

    // Fill the header FIFO, then try one more push while full
    h_n = '{1, 3, 4, 2};
    for (int p = 0; p < 4; p++) begin
      h_data[p] = $urandom;
      push_hdr(h_data[p], h_n[p]);
    end
    chk("full_ready_insert", 64'(bus.ready_insert), 64'(0));
    bus.valid_insert = 1'b1; bus.data_insert = 32'hFFFFFFFF;
    bus.byte_insert_cnt = 3'd4; bus.keep_insert = 4'hF;
    @(posedge clk); #1;
    bus.valid_insert = 1'b0;
    chk("full_ready_insert_hold", 64'(bus.ready_insert), 64'(0));

    // Three 16-beat packets under toggling backpressure
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 16; b++) begin
        pk_data[p][b] = $urandom;
        pk_keep[p][b] = (b == 15) ? last_keeps[$urandom_range(0, 3)] : 4'hF;
      end
      build_expected(p);
    end
    total = exp_q.size();
    bus.ready_out = 1'b1;
    fork
      drive_packets();
      begin
        monitor(total);
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          bus.ready_out = ~bus.ready_out;
        end
      end
    join
    bus.ready_out = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a packet using the fourth queued header (n=2)
    b0 = $urandom;
    bus.valid_in = 1'b1; bus.data_in = b0; bus.keep_in = 4'hF; bus.last_in = 1'b0;
    #1;
    chk("midrst_ready_first", 64'(bus.ready_in), 64'(1));
    @(posedge clk); #1;
    chk("midrst_beat0", 64'(out_vec()), 64'({1'b1, 1'b0, 4'hF, h_data[3][15:0], b0[31:16]}));
    bus.data_in = $urandom;
    @(posedge clk); #1;
    bus.data_in = $urandom;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 64'(out_vec()), 64'(0));
    chk("midrst_ready_in", 64'(bus.ready_in), 64'(0));
    chk("midrst_ready_insert", 64'(bus.ready_insert), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("postrst_ready_in", 64'(bus.ready_in), 64'(0));
    @(posedge clk); #1;
    chk("postrst_out", 64'(out_vec()), 64'(0));
    chk("postrst_ready_in2", 64'(bus.ready_in), 64'(0));
    bus.valid_in = 1'b0;
    push_hdr(32'h00112233, 3);
    apply_vecs(8, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/axis_hdr_insert_q.md
# axis_hdr_insert_q

Parametrised AXI-Stream header inserter: prepends a 0..DATA_BYTE_WD-byte header to each packet and re-packs the payload so the output is byte-contiguous. Headers are queued in a small FIFO, so they can arrive ahead of their packets. The block runs at one beat per clock with full backpressure. It sits between the packet source and the downstream AXI-Stream sink.

## Interface

- DATA_WD, 32 — data width in bits; multiple of 8, at least 16.
- DATA_BYTE_WD, DATA_WD/8 — bytes per beat (W).
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD+1) — header byte-count width; can encode 0..W.
- HDR_FIFO_DEPTH, 4 — number of queued headers; power of 2, at least 2.

Ports:

- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload; byte 0 is data_in[DATA_WD-1 -: 8].
- keep_in  in  DATA_BYTE_WD  all ones except on the last beat, where it is MSB-contiguous.
- last_in  in  1  last payload beat.
- ready_in  out  1  payload accept.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header; the valid bytes are the low byte_insert_cnt bytes.
- keep_insert  in  DATA_BYTE_WD  header keep, LSB-contiguous.
- byte_insert_cnt  in  BYTE_CNT_WD  header length n; values above W are clamped to W.
- ready_insert  out  1  header accept.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  output data; bytes where keep_out is 0 are driven 0.
- keep_out  out  DATA_BYTE_WD  output keep, MSB-contiguous.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.
- hdr_err  out  1  present only with AXIS_HDR_INS_CHECK_EN.

## Operation

Header FIFO:
- Each entry is {data_insert, n}.
- ready_insert = !fifo_full.
- Push happens on valid_insert && ready_insert. A simultaneous pop does not admit a push while the FIFO is full.
- One header is popped per packet, on acceptance of that packet's first beat.

Carry register:
- Holds n bytes (0..W), left-aligned.
- For each accepted beat: the output is {carry[n bytes], the first W-n bytes of data_in}, and the new carry is the last n bytes of data_in.
- On the first beat, the carry is the FIFO head header: its low n bytes are moved to the MSB side.
- n=0: plain pass-through.
- n=W: the header goes out as a whole beat, then the payload is delayed by one beat.

State machine:
- S_FIRST:
  - ready_in = fifo_nonempty && slot_free.
  - On accept: pop header, emit beat, go to S_BODY. If last_in, go to the last-beat rule instead.
- S_BODY:
  - ready_in = slot_free.
  - Emit beat on each accept.
- Last-beat rule, with k = popcount(keep_in):
  - n+k ≤ W: emit a beat with keep = n+k MSB ones, last_out=1, go to S_FIRST.
  - Otherwise: emit a full beat with last_out=0 and go to S_TAIL.
- S_TAIL:
  - ready_in=0.
  - When slot_free: emit the carry with n+k-W bytes, last_out=1, go to S_FIRST.

Output handshake:
- slot_free = !valid_out || ready_out.
- Output signals are registered and held stable while valid_out && !ready_out.

## Timing

- Latency is one cycle: a beat accepted at edge t appears at t+1.
- No bubble between packets when a header is already queued.
- One extra cycle only for a tail beat.
- The header must be in the FIFO one cycle before the first beat is accepted. There is no FIFO bypass.
- Reset (asynchronous, any time, including mid-packet):
  - valid_out=0, data_out=0, keep_out=0, last_out=0, hdr_err=0.
  - FIFO emptied, state S_FIRST, carry cleared.
  - Partial packets and queued headers are discarded.
  - While reset is held: ready_insert=1, ready_in=0.

## Configuration

- AXIS_HDR_INS_CHECK_EN defined:
  - hdr_err pulses for one cycle after either of these:
    - a header push where keep_insert ≠ (1<<n)-1;
    - a non-last payload beat accepted with keep_in ≠ all ones.
  - The datapath is unaffected.
- Not defined: the hdr_err port and its logic are absent. keep_insert is ignored and only n is used.

## Test plan

All scenarios use DATA_WD=32.

1. n=2, header 0x0000AABB; beats 0x11223344 keep F, then 0x55667788 keep 1110 with last. Required output: 0xAABB1122/F, 0x33445566/F, 0x77000000/1000 with last.
2. n=4, header 0xDEADBEEF; single beat 0x01020304 keep 1100 with last. Required output: 0xDEADBEEF/F with last 0, then 0x01020000/1100 with last.
3. n=0; beats 0xCAFEF00D/F, then 0x12345678/1000 with last. Output is identical to input, one cycle later.
4. Three headers queued back-to-back, three random 16-beat packets, ready_out toggling 1,0,1,0. The output byte stream matches the model, with no loss or duplication, outputs stable while stalled, and no inter-packet bubble when ready_out=1.
5. Push 4 headers with no payload: ready_insert=0 after the 4th. After the first beat of a packet is accepted, ready_insert=1 on the next cycle.
6. rst_n pulsed low during S_BODY: valid_out goes to 0 immediately. After release, ready_in=0 until a new header is pushed; the next packet is correct.
